// File: rtl/sd_cmd_pkg.sv
// Shared types and constants for the SD command scheduler slice.
package sd_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_CHECK,
    ST_REPORT
  } sched_state_t;

  typedef enum logic {
    REQ_HOST = 1'b0,
    REQ_DATA = 1'b1
  } req_id_t;

  localparam int unsigned RESP_IDX_HI = 37;
  localparam int unsigned RESP_IDX_LO = 32;

  localparam logic [5:0] NO_IDX_CMD_R2 = 6'd2;
  localparam logic [5:0] NO_IDX_CMD_R3 = 6'd41;

  // R2/R3 responses carry no echoed index, so they cannot be checked.
  function automatic logic has_no_index(input logic [5:0] idx);
    return (idx == NO_IDX_CMD_R2) || (idx == NO_IDX_CMD_R3);
  endfunction

endpackage

// File: rtl/cmd_scheduler_if.sv
// Command path between the scheduler (master) and cmd_controller (slave).
interface cmd_scheduler_if;
  logic        new_command;
  logic [5:0]  cmd_index;
  logic [31:0] argument_reg;
  logic        cmd_idle;
  logic        cmd_ack;
  logic [39:0] response_in;

  modport master (
    output new_command, cmd_index, argument_reg,
    input  cmd_idle, cmd_ack, response_in
  );

  modport slave (
    input  new_command, cmd_index, argument_reg,
    output cmd_idle, cmd_ack, response_in
  );
endinterface

// File: rtl/cmd_rr_arbiter.sv
// Two-input round-robin arbiter; pointer names the preferred requester on a tie.
module cmd_rr_arbiter
  import sd_cmd_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  logic    req_host,
  input  logic    req_data,
  input  logic    upd_en,
  input  req_id_t upd_id,
  output logic    grant_valid,
  output req_id_t grant_id
);

  req_id_t ptr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr <= REQ_HOST;
    end else if (upd_en) begin
      ptr <= (upd_id == REQ_HOST) ? REQ_DATA : REQ_HOST;
    end
  end

  always_comb begin
    grant_valid = req_host | req_data;
    grant_id    = ptr;
    if (req_host && !req_data) begin
      grant_id = REQ_HOST;
    end else if (!req_host && req_data) begin
      grant_id = REQ_DATA;
    end
  end

endmodule

// File: rtl/cmd_scheduler.sv
// Shares the SD command path between HOST and DATA: arbitrate, issue, check, retry, report.
module cmd_scheduler
  import sd_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned MAX_RETRY      = 2,
  parameter int unsigned CNT_W          = 11
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 host_req,
  input  logic [5:0]           host_cmd_index,
  input  logic [31:0]          host_argument,
  output logic                 host_done,
  output logic                 host_timeout,
  input  logic                 data_req,
  input  logic [5:0]           data_cmd_index,
  input  logic [31:0]          data_argument,
  output logic                 data_done,
  output logic                 data_timeout,
  cmd_scheduler_if.master      cmd,
  output logic [39:0]          response_out,
  output logic                 busy
);

  localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  sched_state_t     state, state_nxt;
  req_id_t          owner;
  req_id_t          grant_id;
  logic             grant_valid;
  logic [5:0]       idx_q;
  logic [31:0]      arg_q;
  logic [RTY_W-1:0] retry_q;
  logic [CNT_W-1:0] tmo_q;
  logic             success_q;

  logic load, fire, capture, retry_inc, rep_ok, rep_fail, ptr_upd;
  logic retry_ok, idx_pass, report;

  cmd_rr_arbiter u_arb (
    .clock       (clock),
    .reset       (reset),
    .req_host    (host_req),
    .req_data    (data_req),
    .upd_en      (ptr_upd),
    .upd_id      (owner),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign retry_ok = (retry_q < RTY_MAX);
  assign idx_pass = has_no_index(idx_q) ||
                    (response_out[RESP_IDX_HI:RESP_IDX_LO] == idx_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    fire      = 1'b0;
    capture   = 1'b0;
    retry_inc = 1'b0;
    rep_ok    = 1'b0;
    rep_fail  = 1'b0;
    ptr_upd   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_valid) begin
          load      = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cmd.cmd_idle) begin
          fire      = 1'b1;
          state_nxt = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        // An ack in the same cycle as the timeout event takes priority.
        if (cmd.cmd_ack) begin
          capture   = 1'b1;
          state_nxt = ST_CHECK;
        end else if (tmo_q == TMO_LAST) begin
          if (retry_ok) begin
            retry_inc = 1'b1;
            state_nxt = ST_ISSUE;
          end else begin
            rep_fail  = 1'b1;
            state_nxt = ST_REPORT;
          end
        end
      end
      ST_CHECK: begin
        if (idx_pass) begin
          rep_ok    = 1'b1;
          state_nxt = ST_REPORT;
        end else if (retry_ok) begin
          retry_inc = 1'b1;
          state_nxt = ST_ISSUE;
        end else begin
          rep_fail  = 1'b1;
          state_nxt = ST_REPORT;
        end
      end
      ST_REPORT: begin
        ptr_upd   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner        <= REQ_HOST;
      idx_q        <= '0;
      arg_q        <= '0;
      retry_q      <= '0;
      tmo_q        <= '0;
      success_q    <= 1'b0;
      response_out <= '0;
    end else begin
      if (load) begin
        owner   <= grant_id;
        idx_q   <= (grant_id == REQ_HOST) ? host_cmd_index : data_cmd_index;
        arg_q   <= (grant_id == REQ_HOST) ? host_argument : data_argument;
        retry_q <= '0;
      end
      if (fire) begin
        tmo_q <= '0;
      end else if (state == ST_WAIT_ACK) begin
        tmo_q <= tmo_q + 1'b1;
      end
      if (capture) begin
        response_out <= cmd.response_in;
      end
      if (retry_inc) begin
        retry_q <= retry_q + 1'b1;
      end
      if (rep_ok) begin
        success_q <= 1'b1;
      end else if (rep_fail) begin
        success_q <= 1'b0;
      end
    end
  end

  assign report           = (state == ST_REPORT);
  assign host_done        = report &&  success_q && (owner == REQ_HOST);
  assign host_timeout     = report && !success_q && (owner == REQ_HOST);
  assign data_done        = report &&  success_q && (owner == REQ_DATA);
  assign data_timeout     = report && !success_q && (owner == REQ_DATA);
  assign busy             = (state != ST_IDLE);
  assign cmd.new_command  = fire;
  assign cmd.cmd_index    = idx_q;
  assign cmd.argument_reg = arg_q;

endmodule
